// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester ports (fetch, data), the completion/error
//   returns and the shared memory-bus request/acknowledge signals.
//   slave  : the arbiter's view (requests and bus ack in, bus request and
//            completions out).
//   master : the environment's view (requesters plus memory bus model).
interface mem_arbiter_if;
    // fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    // data requester
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic [31:0] d_rdata;
    // completion status
    logic        err;
    // memory bus
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  m_ack, m_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, err,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output m_ack, m_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, err,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester (instruction fetch, data) arbiter onto one memory bus with
//   a single outstanding transaction. Data wins contention until fetch has
//   been passed over STARVE_LIMIT times in a row; a grant that sees no m_ack
//   for TIMEOUT cycles is aborted and completed with err=1.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave -- requester ports, completions, memory bus
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;

    state_t              state_reg, state_next;
    logic                gnt_d_reg;       // 1: current transaction belongs to data port
    logic                err_reg;
    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic                m_req_reg, m_we_reg;
    logic [31:0]         m_addr_reg, m_wdata_reg;
    logic [3:0]          m_be_reg;
    logic [31:0]         if_rdata_reg, d_rdata_reg;

    logic                grant_if, grant_d, txn_done, timeout_hit, in_gnt;
    logic [31:0]         capture_data;

    // wait_cnt counts GNT cycles already spent without m_ack; when the
    // current cycle is the TIMEOUT-th such cycle and still no m_ack arrives,
    // the transaction is aborted. An m_ack in that same cycle still wins.
    assign in_gnt      = (state_reg == GNT_IF) || (state_reg == GNT_D);
    assign timeout_hit = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        txn_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && starve_cnt_reg == STARVE_W'(STARVE_LIMIT))) begin
                    grant_d    = 1'b1;
                    state_next = GNT_D;
                end else if (bus.if_req) begin
                    grant_if   = 1'b1;
                    state_next = GNT_IF;
                end
            end
            GNT_IF, GNT_D: begin
                if (bus.m_ack || timeout_hit) begin
                    txn_done   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Loads return bus data; stores and aborted transactions return zero.
    always_comb begin
        capture_data = 32'd0;
        if (bus.m_ack && !(gnt_d_reg && m_we_reg))
            capture_data = bus.m_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_d_reg      <= 1'b0;
            err_reg        <= 1'b0;
            starve_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            m_req_reg      <= 1'b0;
            m_we_reg       <= 1'b0;
            m_addr_reg     <= 32'd0;
            m_wdata_reg    <= 32'd0;
            m_be_reg       <= 4'd0;
            if_rdata_reg   <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else if (grant_if) begin
            gnt_d_reg      <= 1'b0;
            err_reg        <= 1'b0;
            starve_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            m_req_reg      <= 1'b1;
            m_we_reg       <= 1'b0;
            m_addr_reg     <= bus.if_addr;
            m_wdata_reg    <= 32'd0;
            m_be_reg       <= 4'b1111;
        end else if (grant_d) begin
            gnt_d_reg      <= 1'b1;
            err_reg        <= 1'b0;
            wait_cnt_reg   <= '0;
            m_req_reg      <= 1'b1;
            m_we_reg       <= bus.d_we;
            m_addr_reg     <= bus.d_addr;
            m_wdata_reg    <= bus.d_wdata;
            m_be_reg       <= bus.d_be;
            // Fetch was passed over: count it, saturating at the limit.
            if (bus.if_req && starve_cnt_reg != STARVE_W'(STARVE_LIMIT))
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end else if (txn_done) begin
            m_req_reg <= 1'b0;
            err_reg   <= !bus.m_ack;
            if (gnt_d_reg)
                d_rdata_reg  <= capture_data;
            else
                if_rdata_reg <= capture_data;
        end else if (in_gnt) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign bus.m_req    = m_req_reg;
    assign bus.m_we     = m_we_reg;
    assign bus.m_addr   = m_addr_reg;
    assign bus.m_wdata  = m_wdata_reg;
    assign bus.m_be     = m_be_reg;
    assign bus.if_rdata = if_rdata_reg;
    assign bus.d_rdata  = d_rdata_reg;
    assign bus.if_ready = (state_reg == RESP) && !gnt_d_reg;
    assign bus.d_ready  = (state_reg == RESP) &&  gnt_d_reg;
    assign bus.err      = (state_reg == RESP) &&  err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8). Expected
//   bus requests and completions are queued when stimulus is driven; a
//   negedge monitor pops and compares them as the DUT produces them. Each
//   scenario task also checks its own timing points inline.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    rsp_t rsp_q[$];
    req_t bus_q[$];

    mem_arbiter_if bus_if();

    mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- monitor
    logic m_req_prev;
    req_t held;
    rsp_t exp_rsp;
    req_t exp_req;

    initial m_req_prev = 1'b0;

    always @(negedge clk) begin
        if (bus_if.if_ready === 1'b1 || bus_if.d_ready === 1'b1) begin
            vectors++;
            if (bus_if.if_ready === 1'b1 && bus_if.d_ready === 1'b1) begin
                miscompares++;
                $display("FAIL ready_exclusive: if_ready=%b d_ready=%b, required not both", bus_if.if_ready, bus_if.d_ready);
            end else if (rsp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: if_ready=%b d_ready=%b with no transaction expected", bus_if.if_ready, bus_if.d_ready);
            end else begin
                exp_rsp = rsp_q.pop_front();
                if (bus_if.d_ready !== exp_rsp.is_d) begin
                    miscompares++;
                    $display("FAIL rsp_port: d_ready=%b, required %b", bus_if.d_ready, exp_rsp.is_d);
                end else if ((exp_rsp.is_d ? bus_if.d_rdata : bus_if.if_rdata) !== exp_rsp.rdata) begin
                    miscompares++;
                    $display("FAIL rsp_rdata: got %h, required %h", exp_rsp.is_d ? bus_if.d_rdata : bus_if.if_rdata, exp_rsp.rdata);
                end else if (bus_if.err !== exp_rsp.err) begin
                    miscompares++;
                    $display("FAIL rsp_err: got %b, required %b", bus_if.err, exp_rsp.err);
                end else begin
                    $display("rsp %s rdata=%h err=%b ok", exp_rsp.is_d ? "D " : "IF", exp_rsp.rdata, exp_rsp.err);
                end
            end
        end else if (bus_if.err !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL err_without_ready: err=%b, required 0", bus_if.err);
        end

        if (bus_if.m_req === 1'b1 && m_req_prev !== 1'b1) begin
            vectors++;
            if (bus_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_grant: m_addr=%h with no grant expected", bus_if.m_addr);
            end else begin
                exp_req = bus_q.pop_front();
                if (bus_if.m_we !== exp_req.we || bus_if.m_addr !== exp_req.addr ||
                    bus_if.m_wdata !== exp_req.wdata || bus_if.m_be !== exp_req.be) begin
                    miscompares++;
                    $display("FAIL bus_req: got we=%b addr=%h wdata=%h be=%b, required we=%b addr=%h wdata=%h be=%b",
                             bus_if.m_we, bus_if.m_addr, bus_if.m_wdata, bus_if.m_be,
                             exp_req.we, exp_req.addr, exp_req.wdata, exp_req.be);
                end else begin
                    $display("grant we=%b addr=%h wdata=%h be=%b ok", exp_req.we, exp_req.addr, exp_req.wdata, exp_req.be);
                end
            end
            held.we    = bus_if.m_we;
            held.addr  = bus_if.m_addr;
            held.wdata = bus_if.m_wdata;
            held.be    = bus_if.m_be;
        end else if (bus_if.m_req === 1'b1) begin
            vectors++;
            if (bus_if.m_we !== held.we || bus_if.m_addr !== held.addr ||
                bus_if.m_wdata !== held.wdata || bus_if.m_be !== held.be) begin
                miscompares++;
                $display("FAIL bus_stable: got addr=%h we=%b, required addr=%h we=%b held during grant",
                         bus_if.m_addr, bus_if.m_we, held.addr, held.we);
            end
        end
        m_req_prev = bus_if.m_req;
    end

    // ---------------------------------------------------------------- tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus_if.m_req    !== 1'b0)  begin miscompares++; $display("FAIL reset_m_req: got %b, required 0", bus_if.m_req); end
        vectors++; if (bus_if.m_we     !== 1'b0)  begin miscompares++; $display("FAIL reset_m_we: got %b, required 0", bus_if.m_we); end
        vectors++; if (bus_if.m_addr   !== 32'd0) begin miscompares++; $display("FAIL reset_m_addr: got %h, required 0", bus_if.m_addr); end
        vectors++; if (bus_if.m_wdata  !== 32'd0) begin miscompares++; $display("FAIL reset_m_wdata: got %h, required 0", bus_if.m_wdata); end
        vectors++; if (bus_if.m_be     !== 4'd0)  begin miscompares++; $display("FAIL reset_m_be: got %b, required 0", bus_if.m_be); end
        vectors++; if (bus_if.if_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_if_ready: got %b, required 0", bus_if.if_ready); end
        vectors++; if (bus_if.d_ready  !== 1'b0)  begin miscompares++; $display("FAIL reset_d_ready: got %b, required 0", bus_if.d_ready); end
        vectors++; if (bus_if.err      !== 1'b0)  begin miscompares++; $display("FAIL reset_err: got %b, required 0", bus_if.err); end
        vectors++; if (bus_if.if_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_if_rdata: got %h, required 0", bus_if.if_rdata); end
        vectors++; if (bus_if.d_rdata  !== 32'd0) begin miscompares++; $display("FAIL reset_d_rdata: got %h, required 0", bus_if.d_rdata); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        $display("reset checked");
    endtask

    task automatic test_fetch();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h100;
        bus_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'd0, be: 4'b1111});
        rsp_q.push_back('{is_d: 1'b0, rdata: 32'h13, err: 1'b0});
        tick();  // GNT cycle 1
        vectors++;
        if (bus_if.m_req !== 1'b1) begin miscompares++; $display("FAIL fetch_m_req_first_gnt: got %b, required 1", bus_if.m_req); end
        tick();  // GNT cycle 2
        tick();  // GNT cycle 3: acknowledge
        bus_if.m_ack   = 1'b1;
        bus_if.m_rdata = 32'h13;
        tick();  // RESP
        bus_if.m_ack  = 1'b0;
        bus_if.if_req = 1'b0;
        vectors++;
        if (bus_if.if_ready !== 1'b1 || bus_if.if_rdata !== 32'h13) begin
            miscompares++;
            $display("FAIL fetch_resp: if_ready=%b if_rdata=%h, required 1 / 00000013", bus_if.if_ready, bus_if.if_rdata);
        end
        vectors++;
        if (bus_if.m_req !== 1'b0) begin miscompares++; $display("FAIL fetch_m_req_drop: got %b, required 0", bus_if.m_req); end
        tick();  // IDLE
        vectors++;
        if (bus_if.if_ready !== 1'b0 || bus_if.if_rdata !== 32'h13) begin
            miscompares++;
            $display("FAIL fetch_idle_hold: if_ready=%b if_rdata=%h, required 0 / 00000013", bus_if.if_ready, bus_if.if_rdata);
        end
    endtask

    task automatic test_store();
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b1;
        bus_if.d_addr  = 32'h2000;
        bus_if.d_wdata = 32'hDEADBEEF;
        bus_if.d_be    = 4'b0011;
        bus_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hDEADBEEF, be: 4'b0011});
        rsp_q.push_back('{is_d: 1'b1, rdata: 32'd0, err: 1'b0});
        tick();  // GNT cycle 1: immediate ack, store data on m_rdata must not be captured
        bus_if.m_ack   = 1'b1;
        bus_if.m_rdata = 32'h12345678;
        tick();  // RESP: minimum three-cycle transaction
        bus_if.m_ack = 1'b0;
        bus_if.d_req = 1'b0;
        vectors++;
        if (bus_if.d_ready !== 1'b1 || bus_if.d_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL store_resp: d_ready=%b d_rdata=%h, required 1 / 00000000", bus_if.d_ready, bus_if.d_rdata);
        end
        tick();
    endtask

    task automatic test_load();
        // A stray acknowledge while idle must do nothing.
        bus_if.m_ack   = 1'b1;
        bus_if.m_rdata = 32'hBAD0BAD0;
        tick();
        bus_if.m_ack = 1'b0;
        tick();
        vectors++;
        if (bus_if.d_ready !== 1'b0 || bus_if.if_ready !== 1'b0 || bus_if.m_req !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ack_ignored: d_ready=%b if_ready=%b m_req=%b, required 0/0/0", bus_if.d_ready, bus_if.if_ready, bus_if.m_req);
        end
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = 32'h2004;
        bus_if.d_wdata = 32'h11;
        bus_if.d_be    = 4'b1111;
        bus_q.push_back('{we: 1'b0, addr: 32'h2004, wdata: 32'h11, be: 4'b1111});
        rsp_q.push_back('{is_d: 1'b1, rdata: 32'hCAFEF00D, err: 1'b0});
        tick();  // GNT 1: inputs changing mid-grant must not reach the bus
        bus_if.d_addr = 32'hFFFF0000;
        bus_if.d_we   = 1'b1;
        tick();  // GNT 2
        bus_if.m_ack   = 1'b1;
        bus_if.m_rdata = 32'hCAFEF00D;
        tick();  // RESP
        bus_if.m_ack  = 1'b0;
        bus_if.d_req  = 1'b0;
        bus_if.d_we   = 1'b0;
        bus_if.d_addr = 32'h2004;
        vectors++;
        if (bus_if.d_ready !== 1'b1 || bus_if.d_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL load_resp: d_ready=%b d_rdata=%h, required 1 / cafef00d", bus_if.d_ready, bus_if.d_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        int k;
        bit done;
        bit exp_d [10];
        for (int i = 0; i < 10; i++) begin
            exp_d[i] = !(i == STARVE_LIMIT || i == 2 * STARVE_LIMIT + 1);
            if (exp_d[i])
                bus_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h55, be: 4'b1010});
            else
                bus_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'd0, be: 4'b1111});
            rsp_q.push_back('{is_d: exp_d[i], rdata: 32'hA0 + i, err: 1'b0});
        end
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h400;
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = 32'h3000;
        bus_if.d_wdata = 32'h55;
        bus_if.d_be    = 4'b1010;
        k    = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            tick();
            if (k == 10 && bus_if.m_req === 1'b0) begin
                bus_if.if_req = 1'b0;
                bus_if.d_req  = 1'b0;
                bus_if.m_ack  = 1'b0;
                done = 1'b1;
            end else begin
                bus_if.m_ack = bus_if.m_req;
                if (bus_if.m_req === 1'b1) begin
                    bus_if.m_rdata = 32'hA0 + k;
                    k++;
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL contention_budget: %0d grants in 100 cycles, required 10", k);
        end
        repeat (2) tick();
    endtask

    task automatic test_timeout(input bit ack_last);
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = 32'h5000;
        bus_if.d_wdata = 32'd0;
        bus_if.d_be    = 4'b1111;
        bus_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'd0, be: 4'b1111});
        rsp_q.push_back('{is_d: 1'b1, rdata: ack_last ? 32'h77 : 32'd0, err: !ack_last});
        repeat (TIMEOUT) tick();  // now in the TIMEOUT-th GNT cycle
        vectors++;
        if (bus_if.m_req !== 1'b1 || bus_if.d_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: m_req=%b d_ready=%b in wait cycle %0d, required 1/0", bus_if.m_req, bus_if.d_ready, TIMEOUT);
        end
        if (ack_last) begin
            bus_if.m_ack   = 1'b1;
            bus_if.m_rdata = 32'h77;
        end
        tick();  // RESP
        bus_if.m_ack = 1'b0;
        bus_if.d_req = 1'b0;
        vectors++;
        if (bus_if.d_ready !== 1'b1 || bus_if.err !== !ack_last || bus_if.m_req !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_resp(ack_last=%0b): d_ready=%b err=%b m_req=%b, required 1/%b/0",
                     ack_last, bus_if.d_ready, bus_if.err, bus_if.m_req, !ack_last);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h600;
        bus_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'd0, be: 4'b1111});
        tick();
        tick();  // GNT_IF cycle 2
        vectors++;
        if (bus_if.m_req !== 1'b1) begin miscompares++; $display("FAIL areset_pre_m_req: got %b, required 1", bus_if.m_req); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_if.m_req !== 1'b0) begin miscompares++; $display("FAIL areset_m_req: got %b before next edge, required 0", bus_if.m_req); end
        bus_if.if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_if.m_ack   = 1'b1;   // late acknowledge for the aborted request
        bus_if.m_rdata = 32'hDEAD;
        tick();
        bus_if.m_ack = 1'b0;
        tick();
        vectors++;
        if (bus_if.if_ready !== 1'b0 || bus_if.m_req !== 1'b0 || bus_if.if_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL areset_late_ack: if_ready=%b m_req=%b if_rdata=%h, required 0/0/0", bus_if.if_ready, bus_if.m_req, bus_if.if_rdata);
        end
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h700;
        bus_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'd0, be: 4'b1111});
        rsp_q.push_back('{is_d: 1'b0, rdata: 32'h99, err: 1'b0});
        tick();
        bus_if.m_ack   = 1'b1;
        bus_if.m_rdata = 32'h99;
        tick();
        bus_if.m_ack  = 1'b0;
        bus_if.if_req = 1'b0;
        vectors++;
        if (bus_if.if_ready !== 1'b1 || bus_if.if_rdata !== 32'h99) begin
            miscompares++;
            $display("FAIL areset_recover: if_ready=%b if_rdata=%h, required 1 / 00000099", bus_if.if_ready, bus_if.if_rdata);
        end
        tick();
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        vectors        = 0;
        miscompares    = 0;
        bus_if.if_req  = 1'b0;
        bus_if.if_addr = 32'd0;
        bus_if.d_req   = 1'b0;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = 32'd0;
        bus_if.d_wdata = 32'd0;
        bus_if.d_be    = 4'd0;
        bus_if.m_ack   = 1'b0;
        bus_if.m_rdata = 32'd0;

        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_contention();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_async_reset();
        repeat (3) tick();

        vectors++;
        if (rsp_q.size() != 0) begin miscompares++; $display("FAIL rsp_drain: %0d completions still expected, required 0", rsp_q.size()); end
        vectors++;
        if (bus_q.size() != 0) begin miscompares++; $display("FAIL bus_drain: %0d grants still expected, required 0", bus_q.size()); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
